// File: rtl/misr_sig_compactor_if.sv
// -----------------------------------------------------------------------------
// misr_sig_compactor_if
// Groups the run-control handshake, the beat stream and the result outputs of
// misr_sig_compactor. clk and rst are not part of this bundle.
//
// Handshake semantics:
//   start/len   : one-cycle run request. It is honoured only while the
//                 compactor is IDLE and is ignored in every other state.
//   in_valid/in_ready : a beat transfers on a rising edge where both are high.
//                 in_ready depends only on the state register and never on
//                 in_valid. The producer may raise, drop or hold in_valid
//                 freely, and in_data is only sampled on a transfer.
//   busy/done   : busy is high for RUN and DONE. done is a one-cycle pulse
//                 in DONE.
//
// Signals:
//   start, len, in_valid, in_data, [in_mask]  driven by the master (producer)
//   in_ready, busy, done, signature, count     driven by the slave (compactor)
//   dbg_state                                   FSM state, for observation only
//
// Optional macro: MISR_X_MASK_EN adds in_mask[IN_W-1:0].
// -----------------------------------------------------------------------------
interface misr_sig_compactor_if #(
    parameter int IN_W  = 7,
    parameter int SIG_W = 16,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
`ifdef MISR_X_MASK_EN
    logic [IN_W-1:0]  in_mask;
`endif
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [LEN_W-1:0] count;
    logic [1:0]       dbg_state;

    modport master (
`ifdef MISR_X_MASK_EN
        output in_mask,
`endif
        output start, len, in_valid, in_data,
        input  in_ready, busy, done, signature, count, dbg_state
    );

    modport slave (
`ifdef MISR_X_MASK_EN
        input  in_mask,
`endif
        input  start, len, in_valid, in_data,
        output in_ready, busy, done, signature, count, dbg_state
    );
endinterface

// File: rtl/misr_sig_compactor.sv
// -----------------------------------------------------------------------------
// misr_sig_compactor
// Multiple-input signature register. It compacts a programmable-length stream
// of output vectors into one SIG_W-bit signature. Each accepted beat shifts
// the signature left by one bit and XORs in the POLY feedback when the MSB was
// set. It then XORs in the zero-extended input vector.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : misr_sig_compactor_if.slave
//          start/len            run request, sampled in IDLE only
//          in_valid/in_data     beat stream, accepted when in_valid && in_ready
//          in_ready             high in RUN only
//          busy                 high in RUN and DONE
//          done                 one-cycle pulse in DONE
//          signature            registered signature
//          count                beats accepted in the current or last run
//          dbg_state            FSM state register
//
// Optional macro: MISR_X_MASK_EN. When it is defined, in_mask bits set to 1
// zero the matching in_data bits before they reach the signature.
//
// Parameter limits: 1 <= IN_W <= SIG_W and SIG_W >= 2.
// -----------------------------------------------------------------------------
module misr_sig_compactor #(
    parameter int               IN_W  = 7,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000,
    parameter int               LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    misr_sig_compactor_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SIG_W-1:0] sig_q,   sig_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q,   len_d;

    logic             accept;
    logic [IN_W-1:0]  data_eff;
    logic [SIG_W-1:0] data_ext;
    logic [SIG_W-1:0] sig_step;
    logic [LEN_W-1:0] count_inc;

    // Outputs that decode the state register alone.
    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.signature = sig_q;
    assign bus.count     = count_q;
    assign bus.dbg_state = state_q;

    assign accept    = bus.in_valid && (state_q == S_RUN);
    assign count_inc = count_q + LEN_W'(1);

`ifdef MISR_X_MASK_EN
    assign data_eff = bus.in_data & ~bus.in_mask;
`else
    assign data_eff = bus.in_data;
`endif

    // Zero-extend by a slice assignment. This stays legal when IN_W == SIG_W,
    // where a zero-width replication would not be.
    always_comb begin
        data_ext           = '0;
        data_ext[IN_W-1:0] = data_eff;
    end

    assign sig_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ data_ext;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                // When start is low, signature and count hold, so the last
                // result stays readable.
                if (bus.start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    len_d   = bus.len;
                    state_d = (bus.len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    sig_d   = sig_step;
                    count_d = count_inc;
                    // The final beat's signature update lands on the same
                    // edge that enters DONE.
                    if (count_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

endmodule
